// File: rtl/crc_codec_engine_if.sv
// ----------------------------------------------------------------------------
// crc_codec_engine_if
// Handshake/bus bundle between a frame source/sink and crc_codec_engine.
//   master : drives i_start, i_mode, i_msg_count, i_message_valid, i_message,
//            i_out_ready; observes the engine outputs.
//   slave  : the engine side (inputs above, drives every o_* signal).
// Signals:
//   i_start/i_mode/i_msg_count   frame start pulse, 0=generate 1=check, words
//   i_message_valid/i_message    message (or stored parity) word stream
//   o_message_ready              engine accepts i_message this cycle
//   i_out_ready                  downstream accepts the parity word
//   o_parity_valid/_out/_last    parity word stream, MS word first
//   o_done/o_error/o_busy        frame complete pulse, check mismatch, busy
// ----------------------------------------------------------------------------
interface crc_codec_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COUNT_BITS = 13
);
  logic                  i_start;
  logic                  i_mode;
  logic [COUNT_BITS-1:0] i_msg_count;
  logic                  i_message_valid;
  logic [DATA_WIDTH-1:0] i_message;
  logic                  o_message_ready;
  logic                  i_out_ready;
  logic                  o_parity_valid;
  logic [DATA_WIDTH-1:0] o_parity_out;
  logic                  o_parity_last;
  logic                  o_done;
  logic                  o_error;
  logic                  o_busy;

  modport master (
    output i_start, i_mode, i_msg_count, i_message_valid, i_message, i_out_ready,
    input  o_message_ready, o_parity_valid, o_parity_out, o_parity_last,
           o_done, o_error, o_busy
  );

  modport slave (
    input  i_start, i_mode, i_msg_count, i_message_valid, i_message, i_out_ready,
    output o_message_ready, o_parity_valid, o_parity_out, o_parity_last,
           o_done, o_error, o_busy
  );
endinterface

// File: rtl/crc_codec_engine.sv
// ----------------------------------------------------------------------------
// crc_codec_engine
// Streaming CRC engine. Absorbs i_msg_count message words per frame (one word
// per cycle, MSB-first, non-reflected), then either emits the CRC as
// HASH_LENGTH/DATA_WIDTH parity words (generate) or consumes that many stored
// parity words and flags any mismatch (check).
// Ports:
//   i_clk    clock
//   i_RESET  asynchronous active-high reset (discards any frame in flight)
//   bus      crc_codec_engine_if.slave: start/mode/count, message stream,
//            parity stream, done/error/busy status
// Optional feature macro: CRC_CODEC_INIT_ONES_EN
//   defined   -> CRC starts at all-ones and every emitted/compared parity
//                slice is inverted (final XOR with all-ones)
//   undefined -> init 0, no final XOR
// All outputs are registered: they are computed from the next-state values.
// ----------------------------------------------------------------------------
module crc_codec_engine #(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     HASH_LENGTH = 64,
  parameter logic [HASH_LENGTH-1:0] POLY        = 64'h42F0E1EBA9EA3693,
  parameter int                     COUNT_BITS  = 13
) (
  input logic               i_clk,
  input logic               i_RESET,
  crc_codec_engine_if.slave bus
);

  localparam int OUTPUT_COUNT = HASH_LENGTH / DATA_WIDTH;
  localparam int IDX_BITS     = $clog2(OUTPUT_COUNT) + 1;
  localparam logic [IDX_BITS-1:0]   IDX_LAST = IDX_BITS'(OUTPUT_COUNT - 1);
  localparam logic [IDX_BITS-1:0]   IDX_ONE  = IDX_BITS'(1);
  localparam logic [COUNT_BITS-1:0] CNT_ONE  = COUNT_BITS'(1);

`ifdef CRC_CODEC_INIT_ONES_EN
  localparam logic [HASH_LENGTH-1:0] CRC_INIT = '1;
  localparam logic [DATA_WIDTH-1:0]  OUT_XOR  = '1;
`else
  localparam logic [HASH_LENGTH-1:0] CRC_INIT = '0;
  localparam logic [DATA_WIDTH-1:0]  OUT_XOR  = '0;
`endif

  typedef enum logic [2:0] {IDLE, ABSORB, GEN_OUT, CHECK, DONE} state_t;

  state_t                  state_q, state_d;
  logic [HASH_LENGTH-1:0]  crc_q, crc_d;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic                    err_q, err_d;
  logic                    ready_q, ready_d;
  logic                    pvalid_q, pvalid_d;
  logic [DATA_WIDTH-1:0]   pout_q, pout_d;
  logic                    plast_q, plast_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic                    msg_beat;
  logic                    out_beat;
  logic [DATA_WIDTH-1:0]   crc_slice;

  // Whole word folded into the CRC in one cycle, MSB first.
  function automatic logic [HASH_LENGTH-1:0] crc_step(
    input logic [HASH_LENGTH-1:0] crc_in,
    input logic [DATA_WIDTH-1:0]  word
  );
    logic [HASH_LENGTH-1:0] c;
    logic                   fb;
    c = crc_in;
    for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
      fb = c[HASH_LENGTH-1] ^ word[b];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign msg_beat  = bus.i_message_valid && ready_q;
  assign out_beat  = pvalid_q && bus.i_out_ready;
  // Current top slice with the final XOR already applied.
  assign crc_slice = crc_q[HASH_LENGTH-1 -: DATA_WIDTH] ^ OUT_XOR;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          mode_d  = bus.i_mode;
          count_d = bus.i_msg_count;
          crc_d   = CRC_INIT;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          if (bus.i_msg_count != '0) state_d = ABSORB;
          else                       state_d = bus.i_mode ? CHECK : GEN_OUT;
        end
      end
      ABSORB: begin
        if (msg_beat) begin
          crc_d = crc_step(crc_q, bus.i_message);
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == count_q - CNT_ONE) state_d = mode_q ? CHECK : GEN_OUT;
        end
      end
      GEN_OUT: begin
        if (out_beat) begin
          crc_d = crc_q << DATA_WIDTH;
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) state_d = DONE;
        end
      end
      CHECK: begin
        if (msg_beat) begin
          if (bus.i_message != crc_slice) err_d = 1'b1;
          crc_d = crc_q << DATA_WIDTH;
          idx_d = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with state_q.
    ready_d  = (state_d == ABSORB) || (state_d == CHECK);
    pvalid_d = (state_d == GEN_OUT);
    pout_d   = (state_d == GEN_OUT) ? (crc_d[HASH_LENGTH-1 -: DATA_WIDTH] ^ OUT_XOR) : '0;
    plast_d  = (state_d == GEN_OUT) && (idx_d == IDX_LAST);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      state_q  <= IDLE;
      crc_q    <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      pvalid_q <= 1'b0;
      pout_q   <= '0;
      plast_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      pvalid_q <= pvalid_d;
      pout_q   <= pout_d;
      plast_q  <= plast_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_message_ready = ready_q;
  assign bus.o_parity_valid  = pvalid_q;
  assign bus.o_parity_out    = pout_q;
  assign bus.o_parity_last   = plast_q;
  assign bus.o_done          = done_q;
  assign bus.o_error         = err_q;
  assign bus.o_busy          = busy_q;

endmodule
